// File: rtl/crc32_pkg.sv
// Shared CRC32 definitions for the Ethernet FCS path.
// TX generator and RX checker both use crc32_step so the two cannot diverge.
package crc32_pkg;

    // Register seed at the start of every frame.
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    // Remainder left in the register after running a good frame, FCS included.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
    // IEEE 802.3 generator polynomial, MSB-first form.
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    // Number of trailing FCS bytes on the wire.
    localparam int          FCS_BYTES     = 4;

    // Frame tracking state of the checker.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } fcs_state_e;

    // One slot of the FCS delay line.
    typedef struct packed {
        logic       valid;
        logic       sof;
        logic [7:0] data;
    } dl_entry_t;

    // One byte of CRC32 update. The register is non-reflected (bit 31 is the
    // feedback tap) while the byte enters bit 0 first, matching wire order.
    // No final XOR is applied here; the residue check absorbs it.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/fcs_delay_line.sv
// Byte shift register that holds back the last FCS_BYTES bytes of a frame.
// A byte only leaves the line once a newer byte has pushed it to the oldest
// slot, so the four trailing FCS bytes are never forwarded.
module fcs_delay_line
    import crc32_pkg::*;
#(
    parameter int DEPTH = FCS_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    input  logic       din_sof,
    output logic       oldest_valid,
    output logic [7:0] oldest_data,
    output logic       oldest_sof
);

    // Slot 0 is the newest byte, slot DEPTH-1 the oldest.
    dl_entry_t line_q [DEPTH];
    dl_entry_t new_entry;

    assign new_entry = '{valid: 1'b1, sof: din_sof, data: din};

    // Shift on push; flush empties the line, and a simultaneous push
    // leaves only the new byte in slot 0 (start of the next frame).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
            if (push) begin
                line_q[0] <= new_entry;
            end
        end else if (push) begin
            line_q[0] <= new_entry;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // The oldest slot being valid means the line is full.
    assign oldest_valid = line_q[DEPTH-1].valid;
    assign oldest_data  = line_q[DEPTH-1].data;
    assign oldest_sof   = line_q[DEPTH-1].sof;

endmodule

// File: rtl/crc32_fcs_checker.sv
// Ethernet RX FCS checker: runs CRC32 over each frame including its FCS,
// flags good/bad against the CRC32 residue, and optionally strips the FCS
// bytes before handing the stream to the ethertype dispatcher.
//
// Stream semantics: rx_* and m_* are valid-only byte streams with no ready.
// A byte transfers in every cycle its valid is high; sof/eof/data are only
// meaningful in such cycles. The consumer must accept every byte.
module crc32_fcs_checker
    import crc32_pkg::*;
#(
    parameter bit STRIP_FCS       = 1'b1,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_sof,
    output logic             m_eof,
    output logic             frame_done,
    output logic             fcs_ok,
    output logic             runt,
    output logic [LEN_W-1:0] frame_len
);

    localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0] SHORT_LEN = LEN_W'(FCS_BYTES + 1);
    localparam logic [LEN_W-1:0] FCS_LEN   = LEN_W'(FCS_BYTES);
    localparam logic [LEN_W-1:0] CNT_MAX   = '1;

    fcs_state_e       state_q;
    fcs_state_e       state_d;
    logic [31:0]      crc_q;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_next;

    logic             sof_in;
    logic             in_frame_byte;
    logic             eof_evt;
    logic             abort_evt;
    logic             long_enough;

    logic             fwd_valid;
    logic [7:0]       fwd_data;
    logic             fwd_sof;
    logic             fwd_eof;
    logic [LEN_W-1:0] len_out;

    logic             done_d;
    logic             ok_d;
    logic             runt_d;
    logic [LEN_W-1:0] len_d;

    // A byte belongs to a frame if it opens one or arrives while one is open.
    // sof and eof are ignored unless rx_valid is high.
    assign sof_in        = rx_valid & rx_sof;
    assign in_frame_byte = rx_valid & (rx_sof | (state_q == S_FRAME));
    assign eof_evt       = in_frame_byte & rx_eof;
    assign abort_evt     = sof_in & (state_q == S_FRAME);

    // An sof byte restarts the CRC from the seed, even mid-frame.
    assign crc_next   = crc32_step(sof_in ? CRC32_INIT : crc_q, rx_data);
    assign count_next = sof_in ? LEN_W'(1)
                      : (count_q == CNT_MAX) ? count_q
                      : count_q + LEN_W'(1);
    // Under FCS_BYTES+1 bytes there is no payload; such frames never pass.
    assign long_enough = (count_next >= SHORT_LEN);

    // Next-state logic: sof always (re)opens a frame unless it is also eof.
    always_comb begin
        state_d = state_q;
        if (sof_in) begin
            state_d = rx_eof ? S_IDLE : S_FRAME;
        end else if ((state_q == S_FRAME) && eof_evt) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CRC and byte count; both return to their idle values at end of frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q   <= CRC32_INIT;
            count_q <= '0;
        end else if (eof_evt) begin
            crc_q   <= CRC32_INIT;
            count_q <= '0;
        end else if (in_frame_byte) begin
            crc_q   <= crc_next;
            count_q <= count_next;
        end
    end

    generate
        if (STRIP_FCS) begin : g_strip
            logic       dl_push;
            logic       dl_flush;
            logic       dl_oldest_valid;
            logic [7:0] dl_oldest_data;
            logic       dl_oldest_sof;

            // The eof byte is FCS3 and is never stored; eof or a new sof
            // discards whatever the line still holds.
            assign dl_push  = in_frame_byte & ~rx_eof;
            assign dl_flush = sof_in | eof_evt;

            fcs_delay_line #(
                .DEPTH(FCS_BYTES)
            ) u_delay (
                .clk         (clk),
                .rst_n       (rst_n),
                .push        (dl_push),
                .flush       (dl_flush),
                .din         (rx_data),
                .din_sof     (sof_in),
                .oldest_valid(dl_oldest_valid),
                .oldest_data (dl_oldest_data),
                .oldest_sof  (dl_oldest_sof)
            );

            // A byte arriving at a full line releases the oldest entry; at eof
            // that entry is the last payload byte. An sof byte drops the line.
            always_comb begin
                fwd_valid = 1'b0;
                fwd_data  = '0;
                fwd_sof   = 1'b0;
                fwd_eof   = 1'b0;
                if (in_frame_byte && !sof_in && dl_oldest_valid) begin
                    fwd_valid = 1'b1;
                    fwd_data  = dl_oldest_data;
                    fwd_sof   = dl_oldest_sof;
                    fwd_eof   = rx_eof;
                end
            end

            assign len_out = count_next - FCS_LEN;
        end else begin : g_pass
            // Every frame byte goes straight through. A frame too short to
            // carry an FCS gets no m_eof, so downstream drops it on frame_done.
            always_comb begin
                fwd_valid = 1'b0;
                fwd_data  = '0;
                fwd_sof   = 1'b0;
                fwd_eof   = 1'b0;
                if (in_frame_byte) begin
                    fwd_valid = 1'b1;
                    fwd_data  = rx_data;
                    fwd_sof   = sof_in;
                    fwd_eof   = rx_eof & long_enough;
                end
            end

            assign len_out = count_next;
        end
    endgenerate

    // Status for the frame that ends or is aborted this cycle. An sof+eof
    // byte mid-frame reports the new 1-byte frame; the abort is implied.
    always_comb begin
        done_d = eof_evt | abort_evt;
        ok_d   = 1'b0;
        runt_d = 1'b0;
        len_d  = '0;
        if (eof_evt) begin
            ok_d   = long_enough & (crc_next == CRC32_RESIDUE);
            runt_d = (count_next < MIN_LEN);
            len_d  = long_enough ? len_out : '0;
        end else if (abort_evt) begin
            runt_d = (count_q < MIN_LEN);
        end
    end

    // Output registers: stream byte and status land in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            runt       <= 1'b0;
            frame_len  <= '0;
        end else begin
            m_valid    <= fwd_valid;
            m_data     <= fwd_data;
            m_sof      <= fwd_sof;
            m_eof      <= fwd_eof;
            frame_done <= done_d;
            fcs_ok     <= ok_d;
            runt       <= runt_d;
            frame_len  <= len_d;
        end
    end

endmodule
